// File: rtl/quantpacker.sv
// quantpacker
//   Requantizes signed scaled products with a runtime arithmetic right shift
//   and round-half-up. It then saturates each result to a BQ-bit activation and
//   packs NPACK activations per output word into a 2-entry
//   first-word-fall-through FIFO.
//
// Build option:
//   QUANTPACKER_RELU_EN  when defined, negative results clamp to 0
//                        (saturation range [0, 2^(BQ-1)-1]).
//
// Ports:
//   clk        clock, all state on rising edge
//   clr        asynchronous active-high reset
//   cfg_shift  right-shift amount (0..BP-1), static while busy
//   in_valid   input value present
//   in_ready   stage accepts input this cycle
//   in_data    signed BP-bit scaled product
//   in_last    final value of a group, forces word emission
//   out_valid  packed word available
//   out_ready  consumer accepts word
//   out_data   packed word, lane 0 in bits [BQ-1:0]
//   out_last   word closes a group
//   busy       any value in pipeline, packer or FIFO
module quantpacker #(
    parameter int unsigned BP    = 48,
    parameter int unsigned BQ    = 8,
    parameter int unsigned NPACK = 4,
    parameter int unsigned BS    = 6
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [BS-1:0]         cfg_shift,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BP-1:0]         in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NPACK*BQ-1:0]   out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int unsigned CW = (NPACK > 1) ? $clog2(NPACK) : 1;
    localparam int unsigned WW = NPACK * BQ;

    localparam logic signed [BP:0] SatMax = (BP+1)'((1 << (BQ - 1)) - 1);
`ifdef QUANTPACKER_RELU_EN
    localparam logic signed [BP:0] SatMin = '0;
`else
    localparam logic signed [BP:0] SatMin = -SatMax - (BP+1)'(1);
`endif

    // Pipeline registers
    logic                 s1_v_q, s2_v_q, s3_v_q;
    logic                 s1_last_q, s2_last_q, s3_last_q;
    logic signed [BP:0]   s1_r_q, s2_q_q;
    logic [BQ-1:0]        s3_a_q;

    // Packer state
    logic [CW-1:0]        cnt_q;
    logic [WW-1:0]        lanes_q;

    // Output FIFO
    logic [WW-1:0]        mem_data_q [2];
    logic                 mem_last_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q;

    logic                 adv, stall, word_done, push, pop, full;
    logic [WW-1:0]        word;
    logic signed [BP:0]   half, s1_r_d, s2_q_d;
    logic [BQ-1:0]        s3_a_d;

    // S1: add the rounding half-LSB at BP+1 bits so it cannot overflow.
    always_comb begin
        half = '0;
        if (cfg_shift != '0) begin
            half = (BP+1)'(1) << (cfg_shift - BS'(1));
        end
        s1_r_d = $signed({in_data[BP-1], in_data}) + half;
    end

    // S2: arithmetic shift
    assign s2_q_d = s1_r_q >>> cfg_shift;

    // S3: saturate
    always_comb begin
        if (s2_q_q > SatMax) begin
            s3_a_d = SatMax[BQ-1:0];
        end else if (s2_q_q < SatMin) begin
            s3_a_d = SatMin[BQ-1:0];
        end else begin
            s3_a_d = s2_q_q[BQ-1:0];
        end
    end

    // Word under construction with the S3 value inserted at the current lane.
    // Lanes above the counter are always zero because lanes_q clears on emission.
    always_comb begin
        word = lanes_q;
        for (int i = 0; i < int'(NPACK); i++) begin
            if (CW'(i) == cnt_q) begin
                word[i*BQ +: BQ] = s3_a_q;
            end
        end
    end

    assign word_done = s3_v_q && ((cnt_q == CW'(NPACK - 1)) || s3_last_q);
    assign full      = (count_q == 2'd2);
    assign pop       = out_valid && out_ready;
    assign stall     = word_done && full && !pop;
    assign adv       = !stall;
    assign push      = word_done && adv;
    assign in_ready  = adv;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
    assign out_last  = out_valid ? mem_last_q[rd_ptr_q] : 1'b0;
    assign busy      = s1_v_q || s2_v_q || s3_v_q || (cnt_q != '0) || (count_q != 2'd0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s2_last_q <= 1'b0;
            s3_last_q <= 1'b0;
            s1_r_q    <= '0;
            s2_q_q    <= '0;
            s3_a_q    <= '0;
        end else if (adv) begin
            s1_v_q    <= in_valid;
            s1_last_q <= in_last;
            s1_r_q    <= s1_r_d;
            s2_v_q    <= s1_v_q;
            s2_last_q <= s1_last_q;
            s2_q_q    <= s2_q_d;
            s3_v_q    <= s2_v_q;
            s3_last_q <= s2_last_q;
            s3_a_q    <= s3_a_d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q   <= '0;
            lanes_q <= '0;
        end else if (adv && s3_v_q) begin
            if (word_done) begin
                cnt_q   <= '0;
                lanes_q <= '0;
            end else begin
                cnt_q   <= cnt_q + CW'(1);
                lanes_q <= word;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 2; i++) begin
                mem_data_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= word;
                mem_last_q[wr_ptr_q] <= s3_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_quantpacker.sv
// Self-checking bench for quantpacker: directed scenarios plus randomized
// groups, all checked against a behavioural requantize-and-pack model.
module tb_quantpacker;

    localparam int unsigned BP    = 48;
    localparam int unsigned BQ    = 8;
    localparam int unsigned NPACK = 4;
    localparam int unsigned BS    = 6;
    localparam int unsigned WW    = NPACK * BQ;

    logic            clk = 1'b0;
    logic            clr;
    logic [BS-1:0]   cfg_shift;
    logic            in_valid;
    logic            in_ready;
    logic [BP-1:0]   in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [WW-1:0]   out_data;
    logic            out_last;
    logic            busy;

    int errors = 0;
    int checks = 0;

    // Model state: partial group and expected words in emission order
    int            m_lanes[$];
    logic [WW-1:0] exp_data_q[$];
    logic          exp_last_q[$];

    quantpacker #(.BP(BP), .BQ(BQ), .NPACK(NPACK), .BS(BS)) dut (
        .clk       (clk),
        .clr       (clr),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round half up, floor divide, then clamp.
    function automatic int act(input logic [BP-1:0] d, input int s);
        longint x, p, r, q, hi, lo;
        x  = longint'($signed(d));
        p  = longint'(1) << s;
        r  = x + ((s == 0) ? 0 : p / 2);
        q  = r / p;
        if ((r % p != 0) && (r < 0)) q = q - 1;
        hi = (longint'(1) << (BQ - 1)) - 1;
`ifdef QUANTPACKER_RELU_EN
        lo = 0;
`else
        lo = -(longint'(1) << (BQ - 1));
`endif
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    task automatic model_accept(input logic [BP-1:0] d, input logic l, input int s);
        logic [WW-1:0] w;
        logic [BQ-1:0] lb;
        m_lanes.push_back(act(d, s));
        if (m_lanes.size() == int'(NPACK) || l) begin
            w = '0;
            foreach (m_lanes[i]) begin
                lb = BQ'(m_lanes[i]);
                w[i*BQ +: BQ] = lb;
            end
            exp_data_q.push_back(w);
            exp_last_q.push_back(l);
            m_lanes.delete();
        end
    endtask

    // Monitor: handshakes are sampled mid-cycle and complete at the next edge.
    always @(negedge clk) begin
        if (!clr) begin
            if (in_valid && in_ready) model_accept(in_data, in_last, int'(cfg_shift));
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    chk("unexpected_word", 64'(out_valid), 64'd0);
                end else begin
                    chk("word_data", 64'(out_data), 64'(exp_data_q[0]));
                    chk("word_last", 64'(out_last), 64'(exp_last_q[0]));
                    void'(exp_data_q.pop_front());
                    void'(exp_last_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [BP-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            if (n > 4) out_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("send_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called in the cycle after the completing value was accepted, with an
    // empty FIFO and out_ready low: word must appear exactly at t+4.
    task automatic expect_word(input string tag, input logic [WW-1:0] w, input logic l);
        tick();
        tick();
        chk({tag, "_early"}, 64'(out_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(w));
        chk({tag, "_last"}, 64'(out_last), 64'(l));
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        chk("drain_idle", 64'(busy), 64'd0);
        chk("drain_model", 64'(exp_data_q.size()), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] w_round, w_sat;
        clr       = 1'b1;
        cfg_shift = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        clr = 1'b0;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

`ifdef QUANTPACKER_RELU_EN
        w_round = 32'h0000_0102;
        w_sat   = 32'h007F_007F;
`else
        w_round = 32'hFEFF_0102;
        w_sat   = 32'h807F_807F;
`endif
        // Rounding at shift 4, with latency check
        cfg_shift = 6'd4;
        send(48'(24), 1'b0);
        send(48'(23), 1'b0);
        send(-48'sd24, 1'b0);
        send(-48'sd25, 1'b0);
        expect_word("round", w_round, 1'b0);
        drain();

        // Saturation at shift 0
        cfg_shift = 6'd0;
        out_ready = 1'b0;
        send(48'(1000), 1'b0);
        send(-48'sd1000, 1'b0);
        send(48'(127), 1'b0);
        send(-48'sd128, 1'b0);
        expect_word("sat", w_sat, 1'b0);
        drain();

        // Partial flush, then next word restarts at lane 0
        out_ready = 1'b0;
        send(48'(5), 1'b0);
        send(48'(5), 1'b1);
        expect_word("flush", 32'h0000_0505, 1'b1);
        drain();
        out_ready = 1'b0;
        send(48'(7), 1'b1);
        expect_word("lane0", 32'h0000_0007, 1'b1);
        drain();

        // Last on lane NPACK-1: exactly one word
        send(48'(1), 1'b0);
        send(48'(2), 1'b0);
        send(48'(3), 1'b0);
        send(48'(4), 1'b1);
        drain();

        // Backpressure: two words buffered, third held in the packer
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(48'(i + 1), 1'b0);
        repeat (5) tick();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_busy", 64'(busy), 64'd1);
        chk("bp_pending", 64'(exp_data_q.size()), 64'd3);
        drain();

        // Reset mid-stream discards partial state
        out_ready = 1'b1;
        send(48'(9), 1'b0);
        send(48'(9), 1'b0);
        clr = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        clr = 1'b0;
        m_lanes.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        for (int i = 0; i < 4; i++) send(48'(i + 1), 1'b0);
        drain();

        // Bubbles: alternating valid
        for (int i = 0; i < 8; i++) begin
            send(48'(i * 3), 1'b0);
            tick();
        end
        drain();

        // Extreme shift
        cfg_shift = 6'(BP - 1);
        send(48'h7FFF_FFFF_FFFF, 1'b0);
        send(48'h8000_0000_0000, 1'b0);
        send(48'(5), 1'b0);
        send(-48'sd5, 1'b1);
        drain();

        // Randomized groups
        for (int g = 0; g < 30; g++) begin
            int nval;
            cfg_shift = 6'($urandom_range(0, BP - 1));
            nval = int'($urandom_range(1, 10));
            for (int k = 0; k < nval; k++) begin
                longint x;
                x = longint'({$urandom, $urandom}) >>> $urandom_range(16, 63);
                out_ready = ($urandom_range(0, 3) != 0);
                send(48'(x), (k == nval - 1) || ($urandom_range(0, 5) == 0));
                if ($urandom_range(0, 3) == 0) tick();
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
